// File: rtl/vram_fetch_reader_pkg.sv
// Shared VRAM port constants, fetch FSM encoding and a length-decode helper
// used by the VRAM fetch reader.
package vram_fetch_reader_pkg;

    localparam int unsigned VramAddrW    = 15;
    localparam int unsigned VramDataW    = 32;
    localparam int unsigned VramSlots    = 4;
    localparam int unsigned VramPortSlot = 1;
    localparam int unsigned LenW         = 8;
    localparam int unsigned RemW         = LenW + 1;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StCancel
    } fetch_state_e;

    // A zero length field encodes the maximum transfer of 2^LenW words.
    function automatic logic [RemW-1:0] len_to_words(input logic [LenW-1:0] len);
        return (len == '0) ? RemW'(1 << LenW) : {1'b0, len};
    endfunction

endpackage

// File: rtl/vram_fetch_reader_if.sv
// VRAM read-port and output-stream signals of the fetch reader.
interface vram_fetch_reader_if;
    import vram_fetch_reader_pkg::*;

    logic [VramAddrW-1:0] mem_addr;
    logic                 mem_strobe;
    logic [VramDataW-1:0] mem_rddata;
    logic                 mem_ack;
    logic [VramDataW-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output mem_addr, mem_strobe, out_data, out_valid,
        input  mem_rddata, mem_ack, out_ready
    );

    modport slave (
        input  mem_addr, mem_strobe, out_data, out_valid,
        output mem_rddata, mem_ack, out_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with same-cycle push/pop, synchronous reset and flush.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] Full = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != Full) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CW'(1);
        end
    end

    assign rdata = mem[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/vram_fetch_reader.sv
// Fetches a run of 32-bit words from a slotted VRAM read port into an output
// FIFO, with at most one request outstanding and abort/flush support.
module vram_fetch_reader
    import vram_fetch_reader_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [VramAddrW-1:0] base_addr,
    input  logic [LenW-1:0]      len,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    vram_fetch_reader_if.master  bus
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CntW:0]   DepthC = (CntW + 1)'(FIFO_DEPTH);
    localparam logic [CntW-1:0] OneC   = CntW'(1);

    fetch_state_e         state_q;
    logic [VramAddrW-1:0] addr_q;
    logic                 strobe_q, prev_strobe_q, busy_q, done_q;
    logic [RemW-1:0]      remaining_q, rem_dec;

    logic                 ack_ok, push, pop, flush, last_pop, fifo_empty;
    logic [CntW-1:0]      fifo_count;
    logic [CntW:0]        occ_next;
    logic [VramDataW-1:0] fifo_rdata;

    always_comb begin
        ack_ok   = bus.mem_ack && prev_strobe_q && (state_q == StFetch);
        push     = ack_ok && !abort;
        pop      = !fifo_empty && bus.out_ready;
        flush    = (state_q == StFetch) && abort;
        rem_dec  = remaining_q - RemW'(1);
        occ_next = {1'b0, fifo_count};
        if (push) occ_next = occ_next + (CntW + 1)'(1);
        if (pop)  occ_next = occ_next - (CntW + 1)'(1);
        last_pop = (state_q == StFetch) && (remaining_q == '0) && pop && (fifo_count == OneC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            strobe_q      <= 1'b0;
            prev_strobe_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            remaining_q   <= '0;
        end else begin
            done_q        <= 1'b0;
            prev_strobe_q <= strobe_q;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StFetch;
                        busy_q      <= 1'b1;
                        addr_q      <= base_addr;
                        strobe_q    <= 1'b1;
                        remaining_q <= len_to_words(len);
                    end
                end
                StFetch: begin
                    if (abort) begin
                        state_q  <= StCancel;
                        strobe_q <= 1'b0;
                    end else begin
                        if (ack_ok) begin
                            addr_q      <= addr_q + VramAddrW'(1);
                            remaining_q <= rem_dec;
                            strobe_q    <= (rem_dec != '0) && (occ_next < DepthC);
                        end else if (!strobe_q) begin
                            strobe_q <= (remaining_q != '0) && (occ_next < DepthC);
                        end
                        if (last_pop) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                end
                // One dead cycle so a late ack for the cancelled request is swallowed.
                StCancel: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (VramDataW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .wdata (bus.mem_rddata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.mem_addr   = addr_q;
    assign bus.mem_strobe = strobe_q;
    assign bus.out_data   = fifo_rdata;
    assign bus.out_valid  = !fifo_empty;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_vram_fetch_reader.sv
// Directed bench for vram_fetch_reader with a 4-slot arbiter model (port at slot 1).
module tb_vram_fetch_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [14:0] base_addr = '0;
    logic [7:0]  len = '0;
    logic        busy, done;

    vram_fetch_reader_if bus_if ();

    vram_fetch_reader #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .bus       (bus_if)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] wexp(input logic [14:0] a);
        return {17'h15A5A, a};
    endfunction

    logic [1:0]  slot = 2'd0;
    logic        ack_q = 1'b0;
    logic [31:0] rdata_q = '0;
    logic        ready = 1'b0;
    int          cyc = 0;
    int          done_cnt = 0;
    logic [31:0] popped[$];
    logic [14:0] svc_addr[$];
    int          svc_cyc[$];

    assign bus_if.mem_ack    = ack_q;
    assign bus_if.mem_rddata = rdata_q;
    assign bus_if.out_ready  = ready;

    // Arbiter: services a strobe in slot 1, acknowledges one cycle later.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        slot    <= slot + 2'd1;
        ack_q   <= bus_if.mem_strobe && (slot == 2'd1);
        rdata_q <= wexp(bus_if.mem_addr);
        if (bus_if.mem_strobe && (slot == 2'd1)) begin
            svc_addr.push_back(bus_if.mem_addr);
            svc_cyc.push_back(cyc);
        end
        if (bus_if.out_valid && bus_if.out_ready) popped.push_back(bus_if.out_data);
        if (done) done_cnt <= done_cnt + 1;
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic pulse_start(input logic [14:0] b, input logic [7:0] l);
        @(negedge clk);
        base_addr = b;
        len = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input string tag);
        int n = 0;
        while (busy && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_svc(input int cnt, input int maxc, input string tag);
        int n = 0;
        while (svc_addr.size() < cnt && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check(tag, svc_addr.size(), cnt);
    endtask

    task automatic clear_logs();
        popped.delete();
        svc_addr.delete();
        svc_cyc.delete();
    endtask

    initial begin
        int d0;
        int errs;
        logic [14:0] a;

        // Reset values
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_strobe", {31'd0, bus_if.mem_strobe}, 0);
        check("rst_addr", {17'd0, bus_if.mem_addr}, 0);
        check("rst_valid", {31'd0, bus_if.out_valid}, 0);

        // Basic fetch of 4 words
        clear_logs();
        ready = 1'b1;
        d0 = done_cnt;
        pulse_start(15'h0100, 8'd4);
        check("t1_busy", {31'd0, busy}, 1);
        check("t1_strobe", {31'd0, bus_if.mem_strobe}, 1);
        check("t1_addr", {17'd0, bus_if.mem_addr}, 32'h0100);
        wait_idle(100, "t1_timeout");
        check("t1_nwords", popped.size(), 4);
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            a = 15'h0100 + 15'(i);
            if (popped[i] !== wexp(a)) errs++;
            if (svc_addr[i] !== a) errs++;
        end
        check("t1_data_order", errs, 0);
        errs = 0;
        for (int i = 0; i < 3; i++) if (svc_cyc[i+1] - svc_cyc[i] != 4) errs++;
        check("t1_strobe_spacing", errs, 0);
        check("t1_nsvc", svc_addr.size(), 4);
        check("t1_done_once", done_cnt - d0, 1);

        // Address wrap
        clear_logs();
        pulse_start(15'h7FFE, 8'd4);
        wait_idle(100, "t2_timeout");
        check("t2_addr0", {17'd0, svc_addr[0]}, 32'h7FFE);
        check("t2_addr1", {17'd0, svc_addr[1]}, 32'h7FFF);
        check("t2_addr2", {17'd0, svc_addr[2]}, 32'h0000);
        check("t2_addr3", {17'd0, svc_addr[3]}, 32'h0001);
        check("t2_data2", popped[2], wexp(15'h0000));

        // Back-pressure: FIFO fills, strobe drops
        clear_logs();
        ready = 1'b0;
        d0 = done_cnt;
        pulse_start(15'h0300, 8'd10);
        repeat (40) @(negedge clk);
        check("t3_nsvc_full", svc_addr.size(), 4);
        check("t3_strobe_low", {31'd0, bus_if.mem_strobe}, 0);
        check("t3_valid", {31'd0, bus_if.out_valid}, 1);
        check("t3_head", bus_if.out_data, wexp(15'h0300));
        check("t3_busy", {31'd0, busy}, 1);
        ready = 1'b1;
        wait_idle(200, "t3_timeout");
        check("t3_nwords", popped.size(), 10);
        errs = 0;
        for (int i = 0; i < 10; i++) if (popped[i] !== wexp(15'h0300 + 15'(i))) errs++;
        check("t3_data_order", errs, 0);
        check("t3_done_once", done_cnt - d0, 1);

        // Abort in the ack cycle
        clear_logs();
        d0 = done_cnt;
        pulse_start(15'h0400, 8'd4);
        wait_svc(1, 20, "t4_svc_timeout");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_strobe_low", {31'd0, bus_if.mem_strobe}, 0);
        check("t4_valid_low", {31'd0, bus_if.out_valid}, 0);
        @(negedge clk);
        check("t4_busy_after_cancel", {31'd0, busy}, 0);
        repeat (4) @(negedge clk);
        check("t4_no_words", popped.size(), 0);
        check("t4_no_done", done_cnt - d0, 0);
        d0 = done_cnt;
        pulse_start(15'h0200, 8'd1);
        wait_idle(50, "t4b_timeout");
        check("t4b_nwords", popped.size(), 1);
        check("t4b_data", popped[0], wexp(15'h0200));
        check("t4b_done_once", done_cnt - d0, 1);

        // Reset while an ack is due next cycle
        clear_logs();
        pulse_start(15'h0500, 8'd4);
        wait_svc(1, 20, "t5_svc_timeout");
        begin
            int n = 0;
            while (!(bus_if.mem_strobe && slot == 2'd1) && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("t5_wait_slot", {31'd0, bus_if.mem_strobe}, 1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        popped.delete();
        check("t5_ack_due", {31'd0, ack_q}, 1);
        check("t5_busy", {31'd0, busy}, 0);
        check("t5_strobe", {31'd0, bus_if.mem_strobe}, 0);
        check("t5_addr", {17'd0, bus_if.mem_addr}, 0);
        check("t5_valid", {31'd0, bus_if.out_valid}, 0);
        check("t5_done", {31'd0, done}, 0);
        @(negedge clk);
        check("t5_valid_after_ack", {31'd0, bus_if.out_valid}, 0);
        check("t5_busy_after_ack", {31'd0, busy}, 0);
        repeat (2) @(negedge clk);
        check("t5_no_words", popped.size(), 0);

        // len=0 fetches 256 words; start while busy ignored
        clear_logs();
        d0 = done_cnt;
        pulse_start(15'h1000, 8'd0);
        repeat (10) @(negedge clk);
        pulse_start(15'h2000, 8'd1);
        wait_idle(1300, "t6_timeout");
        check("t6_nwords", popped.size(), 256);
        errs = 0;
        for (int i = 0; i < 256; i++) if (popped[i] !== wexp(15'h1000 + 15'(i))) errs++;
        check("t6_data_order", errs, 0);
        check("t6_last", popped[255], wexp(15'h10FF));
        check("t6_done_once", done_cnt - d0, 1);
        repeat (5) @(negedge clk);
        check("t6_idle_after", {31'd0, busy}, 0);
        check("t6_strobe_after", {31'd0, bus_if.mem_strobe}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vram_fetch_reader.md
VRAM_FETCH_READER -- requirements
Module: vram_fetch_reader

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, output buffer depth in 32-bit words, power of two, 2..16.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a fetch; honoured only when busy=0.
REQ-005 base_addr  input  15  first 32-bit word address, sampled when start is honoured.
REQ-006 len  input  8  number of words to fetch, sampled with start; 0 means 256.
REQ-007 abort  input  1  cancels the current fetch and flushes the buffer.
REQ-008 busy  output  1  high from the cycle after an honoured start until done or abort.
REQ-009 done  output  1  one-cycle pulse when the last word of a fetch leaves the output.
REQ-010 mem_addr  output  15  word address to the VRAM read-only port.
REQ-011 mem_strobe  output  1  read request to the VRAM port.
REQ-012 mem_rddata  input  32  read data, valid in the cycle mem_ack is high.
REQ-013 mem_ack  input  1  one-cycle acknowledge; arrives exactly one cycle after the arbiter services a strobed slot.
REQ-014 out_data  output  32  buffered word, head of FIFO.
REQ-015 out_valid  output  1  FIFO non-empty.
REQ-016 out_ready  input  1  consumer accepts out_data when out_valid and out_ready are both high.

Function
REQ-017 States IDLE, FETCH, CANCEL; IDLE->FETCH on start while IDLE; FETCH->IDLE on done; FETCH->CANCEL on abort; CANCEL->IDLE after exactly one cycle.
REQ-018 mem_strobe and mem_addr are registered; first strobe is high with mem_addr=base_addr in the cycle after an honoured start.
REQ-019 mem_addr and mem_strobe are held stable while waiting for mem_ack.
REQ-020 An ack is accepted only if mem_strobe was high in the previous cycle and state is FETCH; accepted ack pushes mem_rddata into the FIFO, decrements remaining, and increments mem_addr modulo 2^15 (0x7FFF wraps to 0x0000).
REQ-021 On the edge ending an accepted-ack cycle, mem_strobe stays high only if remaining>0 after decrement and FIFO occupancy after push/pop < FIFO_DEPTH; otherwise it drops.
REQ-022 With mem_strobe low in FETCH, mem_strobe rises on the next edge once remaining>0 and occupancy < FIFO_DEPTH.
REQ-023 At most one request outstanding; FIFO never overflows; a push and pop in the same cycle leave occupancy unchanged.
REQ-024 done pulses and busy falls on the same edge when remaining=0 and the final FIFO word is popped.
REQ-025 abort in FETCH: mem_strobe low next cycle, FIFO emptied (out_valid=0 next cycle), done not pulsed; any ack arriving in CANCEL is discarded.
REQ-026 abort in IDLE or CANCEL has no effect; start while busy or in CANCEL is ignored; start and abort in the same IDLE cycle: start wins.

Reset
REQ-027 rst forces state IDLE, mem_strobe=0, mem_addr=0, busy=0, done=0, out_valid=0, FIFO empty, remaining=0, previous-strobe flag=0.
REQ-028 An ack arriving in the first cycle after reset is discarded (previous-strobe flag=0).

Structure
REQ-029 State encoding and the 15-bit VRAM word-address width live in a shared vera package alongside other VRAM port constants.
REQ-030 The output buffer is a sub-module sync_fifo (parameterised width/depth, synchronous reset, same-cycle push/pop).

Verification
REQ-031 Bench contains a 4-slot arbiter model (port at slot 1); start base=0x0100 len=4, out_ready=1 -> words from 0x0100..0x0103 in order, one strobe per 4 cycles, done once.
REQ-032 base=0x7FFE len=4 -> addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001.
REQ-033 len=10, out_ready=0 -> strobe drops after exactly FIFO_DEPTH=4 words buffered; raise out_ready -> remaining 6 delivered, done once.
REQ-034 abort in the cycle after a strobe is serviced -> ack discarded, out_valid=0, busy=0 after CANCEL, no done; new start base=0x0200 len=1 returns only 0x0200 data.
REQ-035 rst asserted mid-fetch with ack due next cycle -> all outputs at reset values, stray ack ignored, FIFO stays empty.
REQ-036 len=0 -> exactly 256 words fetched, done once; start pulsed while busy -> ignored.
